// File: rtl/core_prefetch.sv
// ============================================================================
// Module   : core_prefetch
// Brief    : Instruction prefetcher; single-outstanding AXI reads into a FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_prefetch #(
   parameter int          AXI_AWIDTH = 32,
   parameter int          AXI_DWIDTH = 32,
   parameter int          DEPTH      = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                          CLK,
   input  logic                          NRST,
   output logic [AXI_AWIDTH-1:0]         AXI_ARADDR,
   output logic                          AXI_ARVALID,
   input  logic                          AXI_ARREADY,
   input  logic [AXI_DWIDTH-1:0]         AXI_RDATA,
   input  logic [1:0]                    AXI_RRESP,
   input  logic                          AXI_RVALID,
   output logic                          AXI_RREADY,
   input  logic                          REDIRECT,
   input  logic [31:0]                   REDIRECT_PC,
   output logic                          INSTR_VALID,
   input  logic                          INSTR_READY,
   output logic [31:0]                   INSTRUCTION,
   output logic [31:0]                   INSTR_PC,
   output logic                          INSTR_ERR,
   output logic [$clog2(DEPTH+1)-1:0]    LEVEL
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [LW-1:0] c_depth = LW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t          r_state, w_state_next;
   logic [31:0]     r_fetch_pc, w_fetch_pc_next;
   logic [31:0]     r_ar_addr;
   logic            r_discard;
   logic [LW-1:0]   r_level, w_level_next;
   logic [PW-1:0]   r_wptr, r_rptr;
   logic [31:0]     r_q_instr [DEPTH];
   logic [31:0]     r_q_pc    [DEPTH];
   logic            r_q_err   [DEPTH];

   logic            w_push, w_pop, w_drop, w_r_hs, w_ar_hs;

   assign w_ar_hs = (r_state == S_ADDR) && AXI_ARREADY;
   assign w_r_hs  = (r_state == S_DATA) && AXI_RVALID;
   // A redirect in the same cycle as the response drops it, just like a pending discard.
   assign w_drop  = r_discard | REDIRECT;
   assign w_push  = w_r_hs & ~w_drop;
   assign w_pop   = INSTR_VALID & INSTR_READY & ~REDIRECT;

   assign w_level_next = REDIRECT ? '0 : (r_level + LW'(w_push) - LW'(w_pop));

   always_comb begin
      w_fetch_pc_next = r_fetch_pc;
      if (REDIRECT)
         w_fetch_pc_next = REDIRECT_PC & 32'hFFFF_FFFC;
      else if (w_ar_hs && !r_discard)
         w_fetch_pc_next = r_fetch_pc + 32'd4;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (REDIRECT || (r_level < c_depth)) w_state_next = S_ADDR;
         S_ADDR: if (AXI_ARREADY) w_state_next = S_DATA;
         S_DATA: begin
            if (AXI_RVALID) begin
               if (w_push && (AXI_RRESP != 2'b00))
                  w_state_next = S_HALT;
               else if (w_level_next < c_depth)
                  w_state_next = S_ADDR;
               else
                  w_state_next = S_IDLE;
            end
         end
         S_HALT: if (REDIRECT) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_ar_addr  <= RESET_PC;
         r_discard  <= 1'b0;
         r_level    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_level    <= w_level_next;
         // ARADDR is captured on entry to ADDR so a redirect there cannot disturb it.
         if ((r_state != S_ADDR) && (w_state_next == S_ADDR))
            r_ar_addr <= w_fetch_pc_next;
         if (w_r_hs)
            r_discard <= 1'b0;
         else if (REDIRECT && ((r_state == S_ADDR) || (r_state == S_DATA)))
            r_discard <= 1'b1;
         if (REDIRECT) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_q_instr[r_wptr] <= 32'(AXI_RDATA);
         r_q_pc[r_wptr]    <= r_ar_addr;
         r_q_err[r_wptr]   <= (AXI_RRESP != 2'b00);
      end
   end

   assign AXI_ARADDR  = r_ar_addr[AXI_AWIDTH-1:0];
   assign AXI_ARVALID = (r_state == S_ADDR);
   assign AXI_RREADY  = (r_state == S_DATA);
   assign INSTR_VALID = (r_level != '0);
   assign INSTRUCTION = r_q_instr[r_rptr];
   assign INSTR_PC    = r_q_pc[r_rptr];
   assign INSTR_ERR   = r_q_err[r_rptr];
   assign LEVEL       = r_level;

endmodule

`default_nettype wire

// File: tb/tb_core_prefetch.sv
// ============================================================================
// Module   : tb_core_prefetch
// Brief    : Directed self-checking bench for core_prefetch with an AXI read slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_core_prefetch;

   logic        CLK = 1'b0;
   logic        NRST;
   logic [31:0] AXI_ARADDR;
   logic        AXI_ARVALID;
   logic        AXI_ARREADY;
   logic [31:0] AXI_RDATA;
   logic [1:0]  AXI_RRESP;
   logic        AXI_RVALID;
   logic        AXI_RREADY;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic [31:0] INSTRUCTION;
   logic [31:0] INSTR_PC;
   logic        INSTR_ERR;
   logic [2:0]  LEVEL;

   core_prefetch #(
      .AXI_AWIDTH (32),
      .AXI_DWIDTH (32),
      .DEPTH      (4),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .CLK         (CLK),
      .NRST        (NRST),
      .AXI_ARADDR  (AXI_ARADDR),
      .AXI_ARVALID (AXI_ARVALID),
      .AXI_ARREADY (AXI_ARREADY),
      .AXI_RDATA   (AXI_RDATA),
      .AXI_RRESP   (AXI_RRESP),
      .AXI_RVALID  (AXI_RVALID),
      .AXI_RREADY  (AXI_RREADY),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .INSTRUCTION (INSTRUCTION),
      .INSTR_PC    (INSTR_PC),
      .INSTR_ERR   (INSTR_ERR),
      .LEVEL       (LEVEL)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_errors = 0;

   // slave state
   logic [31:0] ar_log [64];
   int          ar_cnt;
   int          ar_stall;
   int          err_idx;
   logic        ar_fired;
   logic [31:0] ar_addr_q;
   int          ar_idx_q;
   logic        rv_busy;
   logic [31:0] r_addr;
   int          r_idx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic slave_clear();
      ar_cnt   = 0;
      ar_fired = 1'b0;
      rv_busy  = 1'b0;
      AXI_RVALID  = 1'b0;
      AXI_ARREADY = 1'b0;
   endtask

   // Advance to the next falling edge and decide AXI inputs for the coming rising edge.
   task automatic step();
      @(negedge CLK);
      if (ar_fired) begin
         rv_busy  = 1'b1;
         r_addr   = ar_addr_q;
         r_idx    = ar_idx_q;
         ar_fired = 1'b0;
      end
      AXI_RVALID = rv_busy;
      AXI_RDATA  = r_addr ^ 32'hDEAD_BEEF;
      AXI_RRESP  = (r_idx == err_idx) ? 2'b10 : 2'b00;
      if (rv_busy && AXI_RREADY) rv_busy = 1'b0;
      if (AXI_ARVALID && ar_stall > 0) begin
         AXI_ARREADY = 1'b0;
         ar_stall--;
      end else begin
         AXI_ARREADY = 1'b1;
      end
      if (AXI_ARVALID && AXI_ARREADY && ar_cnt < 64) begin
         ar_fired  = 1'b1;
         ar_addr_q = AXI_ARADDR;
         ar_idx_q  = ar_cnt;
         ar_log[ar_cnt] = AXI_ARADDR;
         ar_cnt++;
      end
   endtask

   task automatic do_reset(input int stall, input int eidx);
      NRST        = 1'b0;
      REDIRECT    = 1'b0;
      REDIRECT_PC = 32'h0;
      INSTR_READY = 1'b0;
      r_addr      = 32'h0;
      r_idx       = -1;
      err_idx     = -1;
      ar_stall    = 0;
      slave_clear();
      step();
      step();
      check("rst_arvalid", {31'b0, AXI_ARVALID}, 32'h0);
      check("rst_rready", {31'b0, AXI_RREADY}, 32'h0);
      check("rst_ivalid", {31'b0, INSTR_VALID}, 32'h0);
      check("rst_level", {29'b0, LEVEL}, 32'h0);
      check("rst_araddr", AXI_ARADDR, 32'h0);
      ar_stall = stall;
      err_idx  = eidx;
      NRST     = 1'b1;
   endtask

   initial begin
      logic [31:0] exp_pc;
      int          pops;
      logic        found;

      // Fill from reset, consumer stalled
      do_reset(0, -1);
      step();
      check("a_first_arvalid", {31'b0, AXI_ARVALID}, 32'h1);
      check("a_first_araddr", AXI_ARADDR, 32'h0);
      step();
      check("a_rready", {31'b0, AXI_RREADY}, 32'h1);
      check("a_ivalid_pre", {31'b0, INSTR_VALID}, 32'h0);
      step();
      check("a_ivalid_post", {31'b0, INSTR_VALID}, 32'h1);
      check("a_level1", {29'b0, LEVEL}, 32'h1);
      check("a_head_pc", INSTR_PC, 32'h0);
      check("a_head_instr", INSTRUCTION, 32'hDEAD_BEEF);
      check("a_araddr2", AXI_ARADDR, 32'h4);
      for (int i = 0; i < 16; i++) step();
      check("a_ar_count", ar_cnt, 4);
      check("a_ar0", ar_log[0], 32'h0);
      check("a_ar1", ar_log[1], 32'h4);
      check("a_ar2", ar_log[2], 32'h8);
      check("a_ar3", ar_log[3], 32'hC);
      check("a_level_full", {29'b0, LEVEL}, 32'h4);
      check("a_no_arvalid", {31'b0, AXI_ARVALID}, 32'h0);

      // Drain continuously
      INSTR_READY = 1'b1;
      exp_pc = 32'h0;
      pops   = 0;
      for (int i = 0; i < 24; i++) begin
         if (INSTR_VALID) begin
            check("b_pc", INSTR_PC, exp_pc);
            check("b_instr", INSTRUCTION, exp_pc ^ 32'hDEAD_BEEF);
            check("b_err", {31'b0, INSTR_ERR}, 32'h0);
            exp_pc += 32'd4;
            pops++;
         end
         check("b_level_max", {31'b0, (LEVEL <= 3'd4)}, 32'h1);
         step();
      end
      INSTR_READY = 1'b0;
      check("b_enough_pops", {31'b0, (pops >= 12)}, 32'h1);

      // Redirect while AR stalled
      do_reset(3, -1);
      step();
      check("c_arvalid", {31'b0, AXI_ARVALID}, 32'h1);
      check("c_araddr0", AXI_ARADDR, 32'h0);
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h0000_0103;
      step();
      REDIRECT = 1'b0;
      check("c_hold_valid", {31'b0, AXI_ARVALID}, 32'h1);
      check("c_hold_addr", AXI_ARADDR, 32'h0);
      check("c_level0", {29'b0, LEVEL}, 32'h0);
      step();
      check("c_hold_addr2", AXI_ARADDR, 32'h0);
      step();
      step();
      step();
      check("c_new_arvalid", {31'b0, AXI_ARVALID}, 32'h1);
      check("c_new_araddr", AXI_ARADDR, 32'h100);
      check("c_dropped", {31'b0, INSTR_VALID}, 32'h0);
      step();
      step();
      check("c_head_pc", INSTR_PC, 32'h100);
      check("c_head_instr", INSTRUCTION, 32'hDEAD_BFEF);

      // Error response on second fetch
      do_reset(0, 1);
      for (int i = 0; i < 12; i++) step();
      check("d_ar_count", ar_cnt, 2);
      check("d_level", {29'b0, LEVEL}, 32'h2);
      check("d_head0_err", {31'b0, INSTR_ERR}, 32'h0);
      INSTR_READY = 1'b1;
      step();
      INSTR_READY = 1'b0;
      check("d_err_pc", INSTR_PC, 32'h4);
      check("d_err_flag", {31'b0, INSTR_ERR}, 32'h1);
      for (int i = 0; i < 6; i++) step();
      check("d_halt_no_ar", ar_cnt, 2);
      check("d_halt_arvalid", {31'b0, AXI_ARVALID}, 32'h0);
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h0000_0040;
      step();
      REDIRECT = 1'b0;
      check("d_flush", {29'b0, LEVEL}, 32'h0);
      step();
      check("d_restart_araddr", AXI_ARADDR, 32'h40);
      check("d_restart_log", ar_log[2], 32'h40);

      // Push, pop and redirect together
      do_reset(0, -1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (AXI_RVALID && AXI_RREADY && LEVEL != 3'd0) found = 1'b1;
      end
      check("e_found", {31'b0, found}, 32'h1);
      INSTR_READY = 1'b1;
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h0000_0200;
      step();
      REDIRECT    = 1'b0;
      INSTR_READY = 1'b0;
      check("e_level", {29'b0, LEVEL}, 32'h0);
      check("e_ivalid", {31'b0, INSTR_VALID}, 32'h0);
      for (int i = 0; i < 4; i++) step();
      check("e_next_ar", ar_log[2], 32'h200);

      // Asynchronous reset during DATA
      do_reset(0, -1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (AXI_RREADY) found = 1'b1;
      end
      check("f_found", {31'b0, found}, 32'h1);
      for (int i = 0; i < 5; i++) step();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (AXI_RREADY) found = 1'b1;
      end
      check("f_found2", {31'b0, found}, 32'h1);
      #2 NRST = 1'b0;
      #1;
      check("f_arvalid", {31'b0, AXI_ARVALID}, 32'h0);
      check("f_rready", {31'b0, AXI_RREADY}, 32'h0);
      check("f_ivalid", {31'b0, INSTR_VALID}, 32'h0);
      check("f_level", {29'b0, LEVEL}, 32'h0);
      slave_clear();
      step();
      NRST = 1'b1;
      step();
      check("f_rel_arvalid", {31'b0, AXI_ARVALID}, 32'h1);
      check("f_rel_araddr", AXI_ARADDR, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
